shift_register_piso_hs: RTL and testbench

Parallel-in serial-out serializer with valid/ready handshakes on both sides. It accepts an N-bit parallel word on `PI` and emits it one bit per accepted cycle on `SO`, with first/last frame markers. It is the transmit-side counterpart of the parallel register stage, turning a parallel word into a serial stream for a downstream deserializer or a pin.

---
 rtl/shift_register_piso_hs.sv | 108 ++++++++++
 tb/tb_shift_register_piso_hs.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shift_register_piso_hs.sv
// Parallel-in serial-out serializer with valid/ready handshakes on both sides and first/last markers.
// Optional even-parity trailer bit is enabled by defining SHIFT_REGISTER_PISO_PARITY_EN.
module shift_register_piso_hs #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] PI,
  input  logic         pi_valid,
  output logic         pi_ready,
  output logic         SO,
  output logic         so_valid,
  input  logic         so_ready,
  output logic         so_first,
  output logic         so_last
);

`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif
  localparam int CW = $clog2(F);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           load, xfer, data_bit;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  logic           par_q, par_d;
`endif

  assign load     = pi_valid && pi_ready;
  assign xfer     = so_valid && so_ready;
  assign data_bit = MSB_FIRST ? sreg_q[N-1] : sreg_q[0];

  // state register; reset wins over any same-cycle load or transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (load) state_d = S_SHIFT;
      S_SHIFT: if (xfer && so_last && !load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // datapath: a load takes precedence, it only coincides with the last-bit transfer
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
    par_d  = par_q;
`endif
    if (load) begin
      sreg_d = PI;
      cnt_d  = '0;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      par_d  = ^PI;
`endif
    end else if (xfer) begin
      sreg_d = MSB_FIRST ? {sreg_q[N-2:0], 1'b0} : {1'b0, sreg_q[N-1:1]};
      cnt_d  = so_last ? '0 : cnt_q + CW'(1);
    end
  end

  // outputs; pi_ready is combinational so the next word lands on the last-bit edge
  always_comb begin
    pi_ready = 1'b1;
    so_valid = 1'b0;
    so_first = 1'b0;
    so_last  = 1'b0;
    SO       = 1'b0;
    if (state_q == S_SHIFT) begin
      so_valid = 1'b1;
      so_first = (cnt_q == '0);
      so_last  = (cnt_q == CW'(F - 1));
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
      SO       = (cnt_q == CW'(N)) ? par_q : data_bit;
`else
      SO       = data_bit;
`endif
      pi_ready = so_ready && so_last;
    end
  end

endmodule

// File: tb/tb_shift_register_piso_hs.sv
// Bench: MSB-first and LSB-first instances share stimulus; a per-instance scoreboard queue checks every bit.
module tb_shift_register_piso_hs;
  localparam int N = 8;
`ifdef SHIFT_REGISTER_PISO_PARITY_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif

  typedef struct { logic [7:0] word; logic [7:0] msb_seq; logic [7:0] lsb_seq; logic par; } vec_t;
  typedef struct { logic so; logic first; logic last; } bit_t;

  logic clk = 1'b0, rst = 1'b1, pi_valid = 1'b0, so_ready = 1'b1;
  logic [N-1:0] PI = '0;
  logic m_rdy, m_so, m_vld, m_first, m_last;
  logic l_rdy, l_so, l_vld, l_first, l_last;

  int total = 0, bad = 0;
  int run_len = 0, max_run = 0, rdy_pulses = 0;
  bit_t q_msb[$], q_lsb[$];
  vec_t tab[8];

  always #5 clk = ~clk;

  shift_register_piso_hs #(.N(N), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .PI(PI), .pi_valid(pi_valid), .pi_ready(m_rdy),
    .SO(m_so), .so_valid(m_vld), .so_ready(so_ready), .so_first(m_first), .so_last(m_last));

  shift_register_piso_hs #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .PI(PI), .pi_valid(pi_valid), .pi_ready(l_rdy),
    .SO(l_so), .so_valid(l_vld), .so_ready(so_ready), .so_first(l_first), .so_last(l_last));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // seq bit 7 is the first bit on the wire
  task automatic push_exp(input logic [7:0] mseq, input logic [7:0] lseq, input logic par);
    for (int i = 0; i < F; i++) begin
      bit_t bm, bl;
      if (i < N) begin
        bm.so = mseq[N-1-i];
        bl.so = lseq[N-1-i];
      end else begin
        bm.so = par;
        bl.so = par;
      end
      bm.first = (i == 0); bm.last = (i == F - 1);
      bl.first = bm.first; bl.last = bm.last;
      q_msb.push_back(bm);
      q_lsb.push_back(bl);
    end
  endtask

  task automatic pop_chk(input bit lsb, input logic so, input logic first, input logic last);
    bit_t e;
    if (lsb ? (q_lsb.size() == 0) : (q_msb.size() == 0)) begin
      total++; bad++;
      $display("FAIL %s_unexpected_bit: got so=%b first=%b last=%b expected none", lsb ? "lsb" : "msb", so, first, last);
    end else begin
      e = lsb ? q_lsb.pop_front() : q_msb.pop_front();
      chk(lsb ? "lsb_bit" : "msb_bit", {29'd0, so, first, last}, {29'd0, e.so, e.first, e.last});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m_vld && so_ready) pop_chk(1'b0, m_so, m_first, m_last);
      if (l_vld && so_ready) pop_chk(1'b1, l_so, l_first, l_last);
      chk("msb_pi_ready", {31'd0, m_rdy}, {31'd0, !m_vld || (so_ready && m_last)});
      chk("lsb_pi_ready", {31'd0, l_rdy}, {31'd0, !l_vld || (so_ready && l_last)});
      if (m_vld) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (m_rdy) rdy_pulses++;
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic load_word(input vec_t v);
    int c = 0;
    PI = v.word;
    pi_valid = 1'b1;
    @(negedge clk);
    while (!m_rdy && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (c >= 200) chk("load_timeout", 32'(c), 32'd0);
    else push_exp(v.msb_seq, v.lsb_seq, v.par);
    @(posedge clk); #1;
    pi_valid = 1'b0;
    PI = ~v.word;
  endtask

  task automatic wait_idle(input string nm);
    int c = 0;
    while ((q_msb.size() != 0 || q_lsb.size() != 0 || m_vld || l_vld) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_drain"}, 32'(q_msb.size() + q_lsb.size() + ((c >= 200) ? 1 : 0)), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tab[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    tab[1] = '{8'h01, 8'h01, 8'h80, 1'b1};
    tab[2] = '{8'hF0, 8'hF0, 8'h0F, 1'b0};
    tab[3] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
    tab[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tab[5] = '{8'h07, 8'h07, 8'hE0, 1'b1};
    tab[6] = '{8'h80, 8'h80, 8'h01, 1'b1};
    tab[7] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};

    // reset held with a word offered: nothing may load
    rst = 1'b1; pi_valid = 1'b1; PI = 8'hA5;
    @(negedge clk);
    chk("rst_so_valid_during", {31'd0, m_vld}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; pi_valid = 1'b0;
    @(negedge clk);
    chk("rst_so_valid", {31'd0, m_vld | l_vld}, 32'd0);
    chk("rst_so", {31'd0, m_so | l_so}, 32'd0);
    chk("rst_first_last", {30'd0, m_first | l_first, m_last | l_last}, 32'd0);
    chk("rst_pi_ready", {30'd0, m_rdy, l_rdy}, 32'd3);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      load_word(tab[i]);
      wait_idle("table");
    end

    // backpressure after bit 2 of F0
    load_word(tab[2]);
    @(posedge clk); #1;
    @(posedge clk); #1;
    so_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_so_hold", {31'd0, m_so}, 32'd1);
      chk("bp_valid_rdy", {30'd0, m_vld, m_rdy}, 32'd2);
      chk("bp_first_last", {30'd0, m_first, m_last}, 32'd0);
    end
    @(posedge clk); #1;
    so_ready = 1'b1;
    wait_idle("bp");

    // back-to-back FF then 00
    max_run = 0; rdy_pulses = 0;
    load_word(tab[3]);
    load_word(tab[4]);
    wait_idle("b2b");
    chk("b2b_run", 32'(max_run), 32'(2 * F));
    chk("b2b_rdy_pulses", 32'(rdy_pulses), 32'd2);

    // abort 07 while bit 4 is on the wire, then send 80
    load_word(tab[5]);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q_msb.delete(); q_lsb.delete();
    @(negedge clk);
    chk("abort_idle", {29'd0, m_vld, m_so, m_rdy}, 32'd1);
    @(posedge clk); #1;
    load_word(tab[6]);
    wait_idle("abort_next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
